// File: rtl/gpio_irq_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_irq_bank                                                |
// | Description : Bank of N_PINS bidirectional GPIO pins with per-pin         |
// |               direction, output data, synchronised input and rise/fall    |
// |               edge interrupt capture aggregated onto int_o. RIB slave.    |
// |               Optional input debounce: define GPIO_DEBOUNCE_EN.            |
// |               Pad tri-state is kept outside:                              |
// |               pad = io_oe_o[i] ? io_pin_o[i] : 1'bz.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpio_irq_bank #(
    parameter int N_PINS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              ack_o,
    input  logic [N_PINS-1:0] io_pin_i,
    output logic [N_PINS-1:0] io_pin_o,
    output logic [N_PINS-1:0] io_oe_o,
    output logic              int_o
);

    localparam logic [7:0] c_OFF_DIR     = 8'h00;
    localparam logic [7:0] c_OFF_OUT     = 8'h04;
    localparam logic [7:0] c_OFF_IN      = 8'h08;
    localparam logic [7:0] c_OFF_RISE_EN = 8'h0C;
    localparam logic [7:0] c_OFF_FALL_EN = 8'h10;
    localparam logic [7:0] c_OFF_STATUS  = 8'h14;
    localparam logic [7:0] c_OFF_MASK    = 8'h18;

    logic [N_PINS-1:0] r_dir;
    logic [N_PINS-1:0] r_out;
    logic [N_PINS-1:0] r_rise_en;
    logic [N_PINS-1:0] r_fall_en;
    logic [N_PINS-1:0] r_status;
    logic [N_PINS-1:0] r_mask;
    logic [N_PINS-1:0] r_prev;
    logic [N_PINS-1:0] r_sync [SYNC_STAGES];

    logic [N_PINS-1:0] w_sync;
    logic [N_PINS-1:0] w_filt;
    logic [N_PINS-1:0] w_evt;
    logic [N_PINS-1:0] w_clr;
    logic [N_PINS-1:0] w_wdata;
    logic [7:0]        w_off;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    assign w_off   = addr_i[7:0];
    assign w_wr    = req_i & we_i;
    assign w_wdata = data_i[N_PINS-1:0];
    assign w_sync  = r_sync[SYNC_STAGES-1];

    // Only the low address byte and the low N_PINS data bits matter.
    assign w_unused_bits = &{1'b0, addr_i[31:8], data_i};

    // Multi-stage synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= io_pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    for (genvar gi = 0; gi < N_PINS; gi++) begin : g_deb
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_filt_bit;

        // Accept a new pin level only after it has held for DEB_CYCLES cycles.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_cnt      <= '0;
                r_filt_bit <= 1'b0;
            end else if (w_sync[gi] == r_filt_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt_bit <= w_sync[gi];
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_filt[gi] = r_filt_bit;
    end
`else
    assign w_filt = w_sync;
`endif

    // Edge qualifiers; prev follows filt every cycle so enabling is glitch-free.
    assign w_evt = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);
    assign w_clr = (w_wr && (w_off == c_OFF_STATUS)) ? w_wdata : '0;

    // Control registers, edge history and sticky status (set beats clear).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_mask    <= '0;
            r_status  <= '0;
            r_prev    <= '0;
        end else begin
            r_prev   <= w_filt;
            r_status <= (r_status & ~w_clr) | w_evt;
            if (w_wr) begin
                case (w_off)
                    c_OFF_DIR:     r_dir     <= w_wdata;
                    c_OFF_OUT:     r_out     <= w_wdata;
                    c_OFF_RISE_EN: r_rise_en <= w_wdata;
                    c_OFF_FALL_EN: r_fall_en <= w_wdata;
                    c_OFF_MASK:    r_mask    <= w_wdata;
                    default:       ;
                endcase
            end
        end
    end

    // Same-cycle read mux; unmapped offsets and non-read cycles return 0.
    always_comb begin
        w_rdata = '0;
        if (req_i && !we_i) begin
            case (w_off)
                c_OFF_DIR:     w_rdata[N_PINS-1:0] = r_dir;
                c_OFF_OUT:     w_rdata[N_PINS-1:0] = r_out;
                c_OFF_IN:      w_rdata[N_PINS-1:0] = w_filt;
                c_OFF_RISE_EN: w_rdata[N_PINS-1:0] = r_rise_en;
                c_OFF_FALL_EN: w_rdata[N_PINS-1:0] = r_fall_en;
                c_OFF_STATUS:  w_rdata[N_PINS-1:0] = r_status;
                c_OFF_MASK:    w_rdata[N_PINS-1:0] = r_mask;
                default:       w_rdata = '0;
            endcase
        end
    end

    assign data_o   = w_rdata;
    assign ack_o    = req_i;
    assign io_oe_o  = r_dir;
    assign io_pin_o = r_dir & r_out;
    assign int_o    = |(r_status & r_mask);

endmodule
`default_nettype wire
